ptw_arbiter: RTL
================

Name: ptw_arbiter

Overview:
Shares the single page-table walker between the instruction TLB and the data TLB. Each TLB's miss request is arbitrated, forwarded to the PTW and locked until the walk completes. The walk response is routed back to the owning TLB, and PTW invalidates are broadcast to both. Sits between the ITLB/DTLB miss FSMs and the PTW.

Parameters:
VPN_W, 27, virtual page number width
ASID_W, 16, address space identifier width
PPN_W, 44, physical page number width
PRV_W, 2, privilege level width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active high
itlb_req_valid_i  in  1  ITLB miss request valid, held until ready
itlb_req_vpn_i  in  VPN_W  ITLB request VPN
itlb_req_asid_i  in  ASID_W  ITLB request ASID
itlb_req_prv_i  in  PRV_W  ITLB privilege level
itlb_ptw_ready_o  out  1  request accepted by PTW for ITLB
itlb_resp_valid_o  out  1  walk response valid for ITLB
dtlb_req_valid_i  in  1  DTLB miss request valid, held until ready
dtlb_req_vpn_i  in  VPN_W  DTLB request VPN
dtlb_req_asid_i  in  ASID_W  DTLB request ASID
dtlb_req_prv_i  in  PRV_W  DTLB privilege level
dtlb_req_store_i  in  1  DTLB request is a store
dtlb_ptw_ready_o  out  1  request accepted by PTW for DTLB
dtlb_resp_valid_o  out  1  walk response valid for DTLB
resp_ppn_o  out  PPN_W  response PPN, broadcast
resp_level_o  out  2  response page level, broadcast
resp_pte_flags_o  out  8  response PTE flags {d,a,g,u,x,w,r,v}, broadcast
resp_error_o  out  1  response error, broadcast
invalidate_o  out  1  invalidate, broadcast to both TLBs
ptw_req_valid_o  out  1  request to PTW
ptw_req_vpn_o  out  VPN_W  muxed VPN
ptw_req_asid_o  out  ASID_W  muxed ASID
ptw_req_prv_o  out  PRV_W  muxed privilege
ptw_req_store_o  out  1  store flag (0 for ITLB)
ptw_req_fetch_o  out  1  fetch flag (1 for ITLB)
ptw_ready_i  in  1  PTW accepts request
ptw_resp_valid_i  in  1  PTW response valid, 1-cycle pulse
ptw_resp_ppn_i  in  PPN_W  PTW PPN
ptw_resp_level_i  in  2  PTW level
ptw_resp_pte_flags_i  in  8  PTW PTE flags
ptw_resp_error_i  in  1  PTW error
ptw_invalidate_i  in  1  TLB invalidate from PTW
busy_o  out  1  state != IDLE
owner_o  out  1  current/last owner: 0 = ITLB, 1 = DTLB
pmu_conflict_o  out  1  pulse: both requesters valid in IDLE

Behaviour:
- Reset: state IDLE, owner 0, RR pointer favours ITLB; all request, ready, response and pmu outputs are 0.
- FSM states:
  - IDLE: if any valid, pick winner (RR: the requester not granted last; a single valid requester wins); mux its fields onto ptw_req_* the same cycle with ptw_req_valid_o = 1; latch owner. If ptw_ready_i, go to WAIT, else go to ISSUE.
  - ISSUE: locked to owner, no re-arbitration; ptw_req_valid_o = owner's valid. ptw_ready_i & owner valid -> WAIT. Owner valid dropped (cancel on invalidate) -> IDLE.
  - WAIT: ptw_req_valid_o = 0. On ptw_resp_valid_i, pulse the owner's resp_valid_o only, then go to IDLE. The RR pointer updates on the transition into WAIT.
- {owner}_ptw_ready_o = ptw_ready_i & ptw_req_valid_o & selected; the non-owner sees 0.
- resp_* are combinational pass-through; invalidate_o = ptw_invalidate_i in every state, including same-cycle with ready or response.
- Invalidate in WAIT: stay in WAIT; the response is still routed to the owner, which discards it.
- ptw_resp_valid_i outside WAIT is ignored (no resp_valid_o).
- Asynchronous reset mid-walk returns to IDLE immediately; the late PTW response is ignored.
- pmu_conflict_o = IDLE & both valid.

Optional Feature:
PTW_ARB_DTLB_PRIO_EN: when defined, arbitration is fixed priority with DTLB always winning ties and the RR pointer removed. When undefined, round-robin as above.

Test Plan:
- ITLB only, vpn=0x1234, ptw_ready_i same cycle -> ptw_req_fetch_o=1, itlb_ptw_ready_o=1, state WAIT; response ppn=0xABC -> itlb_resp_valid_o 1 cycle, dtlb_resp_valid_o=0.
- Both valid from reset -> ITLB granted, pmu_conflict_o=1; after completion both valid again -> DTLB granted.
- DTLB request, ptw_ready_i low 3 cycles, ITLB raises valid meanwhile -> PTW fields stay DTLB; grant only on ready.
- ISSUE, ptw_invalidate_i=1 and DTLB drops valid -> invalidate_o=1, next cycle IDLE, no ready pulse.
- WAIT, invalidate then response -> invalidate_o pulses, owner resp_valid_o=1, IDLE next cycle.
- Reset asserted in WAIT then response -> all outputs 0, no resp_valid_o.

Source files
------------

// File: rtl/ptw_arbiter.sv
// ptw_arbiter: shares one page-table walker between the ITLB and the DTLB.
// A miss request is arbitrated, forwarded to the PTW and held locked until
// the walk response returns. The response goes back to the owning TLB and
// PTW invalidates are broadcast to both TLBs.
// Optional build macro PTW_ARB_DTLB_PRIO_EN: fixed priority, DTLB wins ties
// (no round-robin pointer). Default build: round-robin arbitration.
module ptw_arbiter #(
  parameter int unsigned VPN_W  = 27,
  parameter int unsigned ASID_W = 16,
  parameter int unsigned PPN_W  = 44,
  parameter int unsigned PRV_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              itlb_req_valid_i,
  input  logic [VPN_W-1:0]  itlb_req_vpn_i,
  input  logic [ASID_W-1:0] itlb_req_asid_i,
  input  logic [PRV_W-1:0]  itlb_req_prv_i,
  output logic              itlb_ptw_ready_o,
  output logic              itlb_resp_valid_o,
  input  logic              dtlb_req_valid_i,
  input  logic [VPN_W-1:0]  dtlb_req_vpn_i,
  input  logic [ASID_W-1:0] dtlb_req_asid_i,
  input  logic [PRV_W-1:0]  dtlb_req_prv_i,
  input  logic              dtlb_req_store_i,
  output logic              dtlb_ptw_ready_o,
  output logic              dtlb_resp_valid_o,
  output logic [PPN_W-1:0]  resp_ppn_o,
  output logic [1:0]        resp_level_o,
  output logic [7:0]        resp_pte_flags_o,
  output logic              resp_error_o,
  output logic              invalidate_o,
  output logic              ptw_req_valid_o,
  output logic [VPN_W-1:0]  ptw_req_vpn_o,
  output logic [ASID_W-1:0] ptw_req_asid_o,
  output logic [PRV_W-1:0]  ptw_req_prv_o,
  output logic              ptw_req_store_o,
  output logic              ptw_req_fetch_o,
  input  logic              ptw_ready_i,
  input  logic              ptw_resp_valid_i,
  input  logic [PPN_W-1:0]  ptw_resp_ppn_i,
  input  logic [1:0]        ptw_resp_level_i,
  input  logic [7:0]        ptw_resp_pte_flags_i,
  input  logic              ptw_resp_error_i,
  input  logic              ptw_invalidate_i,
  output logic              busy_o,
  output logic              owner_o,
  output logic              pmu_conflict_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_owner;
  logic       w_owner_nxt;
  logic       w_both;
  logic       w_any;
  logic       w_pick;
  logic       w_sel;
  logic       w_sel_valid;
  logic       w_req_valid;
  logic       w_grant;
  logic       w_resp_hit;

  assign w_both = itlb_req_valid_i & dtlb_req_valid_i;
  assign w_any  = itlb_req_valid_i | dtlb_req_valid_i;

`ifdef PTW_ARB_DTLB_PRIO_EN
  // DTLB wins whenever it is requesting.
  assign w_pick = dtlb_req_valid_i;
`else
  // 1 = DTLB favoured on a tie; flips to the other requester after each grant.
  logic r_rr_dtlb;

  assign w_pick = w_both ? r_rr_dtlb : dtlb_req_valid_i;

  // Round-robin pointer advances only when a request is accepted (entry to WAIT).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_dtlb <= 1'b0;
    end else if (w_grant) begin
      r_rr_dtlb <= ~w_sel;
    end
  end
`endif

  // In IDLE the arbitration result drives the PTW directly; afterwards the lock holds.
  assign w_sel       = (r_state == IDLE) ? w_pick : r_owner;
  assign w_sel_valid = w_sel ? dtlb_req_valid_i : itlb_req_valid_i;
  assign w_req_valid = ~rst_i & (((r_state == IDLE) & w_any) |
                                 ((r_state == ISSUE) & w_sel_valid));
  assign w_grant     = w_req_valid & ptw_ready_i;
  assign w_resp_hit  = ~rst_i & (r_state == WAIT) & ptw_resp_valid_i;

  // Next-state: arbitrate in IDLE, hold lock in ISSUE, await the walk in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_owner_nxt = w_pick;
          w_state_nxt = ptw_ready_i ? WAIT : ISSUE;
        end
      end
      ISSUE: begin
        if (w_grant) begin
          w_state_nxt = WAIT;
        end else if (!w_sel_valid) begin
          // Owner withdrew its request (e.g. cancelled by an invalidate).
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (ptw_resp_valid_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and owner registers; reset aborts any walk in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  assign ptw_req_valid_o  = w_req_valid;
  assign ptw_req_vpn_o    = w_req_valid ? (w_sel ? dtlb_req_vpn_i : itlb_req_vpn_i) : '0;
  assign ptw_req_asid_o   = w_req_valid ? (w_sel ? dtlb_req_asid_i : itlb_req_asid_i) : '0;
  assign ptw_req_prv_o    = w_req_valid ? (w_sel ? dtlb_req_prv_i : itlb_req_prv_i) : '0;
  assign ptw_req_store_o  = w_req_valid & w_sel & dtlb_req_store_i;
  assign ptw_req_fetch_o  = w_req_valid & ~w_sel;

  assign itlb_ptw_ready_o = w_grant & ~w_sel;
  assign dtlb_ptw_ready_o = w_grant & w_sel;

  assign itlb_resp_valid_o = w_resp_hit & ~r_owner;
  assign dtlb_resp_valid_o = w_resp_hit & r_owner;
  assign resp_ppn_o        = ptw_resp_ppn_i;
  assign resp_level_o      = ptw_resp_level_i;
  assign resp_pte_flags_o  = ptw_resp_pte_flags_i;
  assign resp_error_o      = ptw_resp_error_i;
  assign invalidate_o      = ptw_invalidate_i;

  assign busy_o         = (r_state != IDLE);
  assign owner_o        = r_owner;
  assign pmu_conflict_o = ~rst_i & (r_state == IDLE) & w_both;

endmodule
